// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the datapath control sequencer:
// FSM states, instruction classes, opcode/ALU/shift codes and field positions.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WR_REG,
    S_WR_IMM,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_IMM,
    CLS_MOVR,
    CLS_ALU2,
    CLS_CMP,
    CLS_UNARY,
    CLS_ILL
  } cls_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_MSB  = 10;
  localparam int RN_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_MSB  = 2;
  localparam int RM_LSB  = 0;
  localparam int IMM_MSB = 7;

  typedef struct packed {
    cls_t       cls;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] sh;
  } dec_t;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decode: field extraction, imm8 sign-extension
// and classification of the instruction into the sequencer's execution classes.
module instr_dec
  import ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] instr,
  output dec_t          dec,
  output logic [DW-1:0] sximm8
);

  logic [2:0] opc;

  assign opc    = instr[OPC_MSB:OPC_LSB];
  assign sximm8 = {{(DW-8){instr[IMM_MSB]}}, instr[IMM_MSB:0]};

  always_comb begin
    dec.op  = instr[OP_MSB:OP_LSB];
    dec.rn  = instr[RN_MSB:RN_LSB];
    dec.rd  = instr[RD_MSB:RD_LSB];
    dec.rm  = instr[RM_MSB:RM_LSB];
    dec.sh  = instr[SH_MSB:SH_LSB];
    dec.cls = CLS_ILL;
    if (opc == OPC_MOV && dec.op == OP_MOV_IMM) begin
      dec.cls = CLS_IMM;
    end else if (opc == OPC_MOV && dec.op == OP_MOV_REG) begin
      dec.cls = CLS_MOVR;
    end else if (opc == OPC_ALU) begin
      case (dec.op)
        ALU_CMP: dec.cls = CLS_CMP;
        ALU_MVN: dec.cls = CLS_UNARY;
        default: dec.cls = CLS_ALU2;
      endcase
    end
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer: accepts one instruction via start/busy/done and
// drives the datapath control inputs cycle by cycle to execute it.
module datapath_ctrl
  import ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] instr,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic          vsel,
  output logic          write,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [DW-1:0] datapath_in
);

  state_t        state_q, state_d;
  logic [DW-1:0] instr_q, instr_d;
  dec_t          dec;
  logic [DW-1:0] sximm8;

  instr_dec #(.DW(DW)) u_dec (
    .instr  (instr_q),
    .dec    (dec),
    .sximm8 (sximm8)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // The instruction register only loads on an accepted start, so instr may move freely while busy.
  always_comb begin
    instr_d = instr_q;
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (start) begin
          state_d = S_DECODE;
          instr_d = instr;
        end
      end
      S_DECODE: begin
        case (dec.cls)
          CLS_IMM:           state_d = S_WR_IMM;
          CLS_ALU2, CLS_CMP: state_d = S_LOAD_A;
          CLS_MOVR, CLS_UNARY: state_d = S_LOAD_B;
          default:           state_d = S_DONE;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC:   state_d = (dec.cls == CLS_CMP) ? S_DONE : S_WR_REG;
      S_WR_REG: state_d = S_DONE;
      S_WR_IMM: state_d = S_DONE;
      S_DONE:   state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_WAIT);
    done        = 1'b0;
    illegal     = 1'b0;
    readnum     = 3'd0;
    writenum    = 3'd0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    vsel        = 1'b0;
    write       = 1'b0;
    shift       = SH_NONE;
    ALUop       = ALU_ADD;
    datapath_in = sximm8;
    case (state_q)
      S_LOAD_A: begin
        readnum = dec.rn;
        loada   = 1'b1;
      end
      S_LOAD_B: begin
        readnum = dec.rm;
        loadb   = 1'b1;
      end
      // MOV reg runs as 0 + shifted B; MVN ignores A, so both zero the A input.
      S_EXEC: begin
        shift = dec.sh;
        ALUop = (dec.cls == CLS_MOVR) ? ALU_ADD : dec.op;
        asel  = (dec.cls == CLS_MOVR) || (dec.cls == CLS_UNARY);
        loadc = (dec.cls != CLS_CMP);
        loads = (dec.cls == CLS_CMP);
      end
      S_WR_REG: begin
        writenum = dec.rd;
        write    = 1'b1;
      end
      S_WR_IMM: begin
        vsel     = 1'b1;
        writenum = dec.rn;
        write    = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = (dec.cls == CLS_ILL);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a behavioural datapath is driven by the DUT and its
// register file is checked against an instruction-level reference model.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        busy, done, illegal;
  logic [2:0]  readnum, writenum;
  logic        loada, loadb, loadc, loads, asel, bsel, vsel, write;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  datapath_ctrl #(.DW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .busy(busy), .done(done), .illegal(illegal),
    .readnum(readnum), .writenum(writenum),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
    .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'd1:    return {v[14:0], 1'b0};
      2'd2:    return {1'b0, v[15:1]};
      2'd3:    return {v[15], v[15:1]};
      default: return v;
    endcase
  endfunction

  // Behavioural datapath stand-in driven purely by the controller outputs.
  logic [15:0] dp_regs [8] = '{default: 16'h0};
  logic [15:0] dp_a = 16'h0, dp_b = 16'h0, dp_c = 16'h0;
  logic        dp_status = 1'b0;
  logic [15:0] sh_b, ain, bin, alu_out;

  always_comb begin
    sh_b = shf(dp_b, shift);
    ain  = asel ? 16'h0 : dp_a;
    bin  = bsel ? 16'h0 : sh_b;
    case (ALUop)
      2'd0:    alu_out = ain + bin;
      2'd1:    alu_out = ain - bin;
      2'd2:    alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (loada) dp_a <= dp_regs[readnum];
    if (loadb) dp_b <= dp_regs[readnum];
    if (loadc) dp_c <= alu_out;
    if (loads) dp_status <= (alu_out == 16'h0);
    if (write) dp_regs[writenum] <= vsel ? datapath_in : dp_c;
  end

  // Instruction-level reference: architectural effect of each instruction.
  logic [15:0] ref_regs [8] = '{default: 16'h0};
  logic        ref_status = 1'b0;

  function automatic int ref_lat(input logic [15:0] ins);
    if (ins[15:13] == 3'b110 && ins[12:11] == 2'b10) return 3;
    if (ins[15:13] == 3'b110 && ins[12:11] == 2'b00) return 5;
    if (ins[15:13] == 3'b101) return (ins[12:11] == 2'b00 || ins[12:11] == 2'b10) ? 6 : 5;
    return 2;
  endfunction

  task automatic ref_exec(input logic [15:0] ins);
    logic [15:0] a, b;
    a = ref_regs[ins[10:8]];
    b = shf(ref_regs[ins[2:0]], ins[4:3]);
    if (ins[15:13] == 3'b110 && ins[12:11] == 2'b10)
      ref_regs[ins[10:8]] = {{8{ins[7]}}, ins[7:0]};
    else if (ins[15:13] == 3'b110 && ins[12:11] == 2'b00)
      ref_regs[ins[7:5]] = b;
    else if (ins[15:13] == 3'b101) begin
      case (ins[12:11])
        2'd0: ref_regs[ins[7:5]] = a + b;
        2'd1: ref_status = (a == b);
        2'd2: ref_regs[ins[7:5]] = a & b;
        default: ref_regs[ins[7:5]] = ~b;
      endcase
    end
  endtask

  typedef struct packed {
    logic loada, loadb, loadc, loads, write, vsel, asel;
    logic [2:0] readnum, writenum;
    logic [1:0] shift, aluop;
    logic [15:0] din;
    logic done, ill, busy;
  } snap_t;
  snap_t trace [0:23];

  task automatic run_instr(input logic [15:0] ins, output int lat, output logic ill,
                           output int nwr, output logic onehot_ok, output logic any_ctl,
                           output logic [15:0] din);
    int w;
    @(negedge clk);
    w = 0;
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_wait: busy still 1 want 0");
    end
    start = 1'b1;
    instr = ins;
    @(posedge clk);
    #1;
    start = 1'b0;
    instr = 16'($urandom);
    lat = -1; ill = 1'b0; nwr = 0; onehot_ok = 1'b1; any_ctl = 1'b0; din = 16'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      trace[k] = {loada, loadb, loadc, loads, write, vsel, asel, readnum, writenum,
                  shift, ALUop, datapath_in, done, illegal, busy};
      if (write) nwr++;
      if ((32'(loada) + 32'(loadb) + 32'(loadc) + 32'(write)) > 1) onehot_ok = 1'b0;
      any_ctl = any_ctl | loada | loadb | loadc | loads | write;
      if (done) begin
        lat = k; ill = illegal; din = datapath_in;
        break;
      end
    end
    ref_exec(ins);
  endtask

  typedef struct {
    logic [15:0] ins;
    int          lat;
    logic        ill;
    int          nwr;
    logic [15:0] din;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int lat, nwr;
    logic ill, oh, anyc;
    logic [15:0] din, r5_before;
    int nd, nw;

    vecs[0]  = '{16'hD003, 3, 1'b0, 1, 16'h0003};
    vecs[1]  = '{16'hD1FF, 3, 1'b0, 1, 16'hFFFF};
    vecs[2]  = '{16'hD080, 3, 1'b0, 1, 16'hFF80};
    vecs[3]  = '{16'hD77F, 3, 1'b0, 1, 16'h007F};
    vecs[4]  = '{16'hC0E1, 5, 1'b0, 1, 16'hFFE1};
    vecs[5]  = '{16'hA049, 6, 1'b0, 1, 16'h0049};
    vecs[6]  = '{16'hB049, 6, 1'b0, 1, 16'h0049};
    vecs[7]  = '{16'hA800, 5, 1'b0, 0, 16'h0000};
    vecs[8]  = '{16'hB8E2, 5, 1'b0, 1, 16'hFFE2};
    vecs[9]  = '{16'hE000, 2, 1'b1, 0, 16'h0000};
    vecs[10] = '{16'hC800, 2, 1'b1, 0, 16'h0000};
    vecs[11] = '{16'hD800, 2, 1'b1, 0, 16'h0000};
    vecs[12] = '{16'h0000, 2, 1'b1, 0, 16'h0000};
    vecs[13] = '{16'h8123, 2, 1'b1, 0, 16'h0023};

    #2;
    chk("reset_outputs", 32'(|{busy, done, illegal, readnum, writenum, loada, loadb, loadc,
        loads, asel, bsel, vsel, write, shift, ALUop, datapath_in}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].ins, lat, ill, nwr, oh, anyc, din);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_illegal", i), 32'(ill), 32'(vecs[i].ill));
      chk($sformatf("vec%0d_writes", i), 32'(nwr), 32'(vecs[i].nwr));
      chk($sformatf("vec%0d_datapath_in", i), 32'(din), 32'(vecs[i].din));
      chk($sformatf("vec%0d_onehot", i), 32'(oh), 32'd1);
      if (vecs[i].ill) chk($sformatf("vec%0d_no_ctl", i), 32'(anyc), 32'd0);
    end

    // MOV R0,#3 cycle-level view.
    run_instr(16'hD003, lat, ill, nwr, oh, anyc, din);
    chk("movimm_c2_write", 32'({trace[2].write, trace[2].vsel, trace[2].writenum}), 32'b1_1_000);
    chk("movimm_c2_din", 32'(trace[2].din), 32'h0003);
    chk("movimm_done_c3", 32'(lat), 32'd3);

    // MOV R1,#4 then ADD R2,R0,R1 LSL#1.
    run_instr(16'hD104, lat, ill, nwr, oh, anyc, din);
    run_instr(16'hA049, lat, ill, nwr, oh, anyc, din);
    chk("add_lat", 32'(lat), 32'd6);
    chk("add_c1_idle", 32'({trace[1].loada, trace[1].loadb, trace[1].loadc, trace[1].write}), 32'd0);
    chk("add_c2_loada", 32'({trace[2].loada, trace[2].loadb, trace[2].loadc, trace[2].write, trace[2].readnum}), 32'b1000_000);
    chk("add_c3_loadb", 32'({trace[3].loada, trace[3].loadb, trace[3].loadc, trace[3].write, trace[3].readnum}), 32'b0100_001);
    chk("add_c4_exec", 32'({trace[4].loadc, trace[4].loads, trace[4].shift, trace[4].aluop, trace[4].asel}), 32'b10_01_00_0);
    chk("add_c5_wr", 32'({trace[5].write, trace[5].vsel, trace[5].writenum}), 32'b1_0_010);
    chk("add_r2", 32'(dp_regs[2]), 32'h000B);

    // CMP R0,R0.
    run_instr(16'hA800, lat, ill, nwr, oh, anyc, din);
    chk("cmp_exec_loads_loadc", 32'({trace[4].loads, trace[4].loadc}), 32'b10);
    chk("cmp_no_write", 32'(nwr), 32'd0);
    chk("cmp_status", 32'(dp_status), 32'd1);

    // Randomized instructions against the reference.
    for (int t = 0; t < 80; t++) begin
      logic [15:0] ins;
      case ($urandom_range(0, 7))
        0, 1:    ins = {3'b110, 2'b10, 3'($urandom), 8'($urandom)};
        2:       ins = {3'b110, 2'b00, 3'($urandom), 8'($urandom)};
        7:       ins = 16'($urandom);
        default: ins = {3'b101, 2'($urandom), 3'($urandom), 8'($urandom)};
      endcase
      run_instr(ins, lat, ill, nwr, oh, anyc, din);
      chk($sformatf("rnd%0d_%04h_lat", t, ins), 32'(lat), 32'(ref_lat(ins)));
      chk($sformatf("rnd%0d_%04h_ill", t, ins), 32'(ill), 32'(ref_lat(ins) == 2));
      chk($sformatf("rnd%0d_onehot", t), 32'(oh), 32'd1);
      for (int r = 0; r < 8; r++)
        chk($sformatf("rnd%0d_%04h_R%0d", t, ins, r), 32'(dp_regs[r]), 32'(ref_regs[r]));
      chk($sformatf("rnd%0d_status", t), 32'(dp_status), 32'(ref_status));
    end

    // start held high across two MOV imm; instr changes while busy.
    @(negedge clk);
    start = 1'b1;
    instr = 16'hD305;
    @(posedge clk);
    #1;
    instr = 16'hD407;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      trace[k] = {loada, loadb, loadc, loads, write, vsel, asel, readnum, writenum,
                  shift, ALUop, datapath_in, done, illegal, busy};
    end
    start = 1'b0;
    ref_exec(16'hD305);
    ref_exec(16'hD407);
    chk("hold_c2_first", 32'({trace[2].write, trace[2].writenum, trace[2].din}), {12'h0, 1'b1, 3'd3, 16'h0005});
    chk("hold_c3_done", 32'({trace[3].done, trace[3].busy}), 32'b11);
    chk("hold_c4_wait", 32'(trace[4].busy), 32'd0);
    chk("hold_c5_busy", 32'(trace[5].busy), 32'd1);
    chk("hold_c6_second", 32'({trace[6].write, trace[6].writenum, trace[6].din}), {12'h0, 1'b1, 3'd4, 16'h0007});
    chk("hold_c7_done", 32'(trace[7].done), 32'd1);
    chk("hold_r3", 32'(dp_regs[3]), 32'h0005);
    chk("hold_r4", 32'(dp_regs[4]), 32'h0007);

    // Reset during EXEC of ADD R5,R0,R1 LSL#1.
    repeat (2) @(negedge clk);
    r5_before = dp_regs[5];
    start = 1'b1;
    instr = 16'hA0A9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_in_exec", 32'(loadc), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_outputs", 32'(|{busy, done, illegal, readnum, writenum, loada, loadb, loadc,
        loads, asel, bsel, vsel, write, shift, ALUop, datapath_in}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    nw = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) nd++;
      if (write) nw++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_no_write", 32'(nw), 32'd0);
    chk("abort_r5", 32'(dp_regs[5]), 32'(r5_before));
    chk("abort_din_cleared", 32'(datapath_in), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
